id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and EX-side operand forwarding; sits directly upstream of the ALU.
//  Captures decoded instruction fields each cycle and resolves RAW hazards by EX/MEM and MEM/WB bypass.
//  Drives ALU operands A/B and ALU control (ALUcontrol_In).
//  Detects load-use hazards: inserts a bubble and stalls fetch/decode for one cycle.
// PARAMETERS
//  XLEN      32  datapath width
//  REG_AW    5   register index width; x0 hard-wired zero, never forwarded
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  reset          in   1      synchronous, active-high
//  id_valid       in   1      decode slot holds a real instruction
//  id_rs1/id_rs2  in   REG_AW source register indices
//  id_uses_rs2    in   1      instruction reads rs2 (R-type, store, branch)
//  id_rd          in   REG_AW destination index
//  id_rs1_data    in   XLEN   register-file read, port 1
//  id_rs2_data    in   XLEN   register-file read, port 2
//  id_imm         in   XLEN   sign-extended immediate
//  id_alusrc      in   1      1: ALU B = immediate
//  id_alu_ctrl    in   4      ALU operation code
//  id_regwrite/id_memread/id_memwrite/id_memtoreg  in 1 each  stage control bits
//  stall_in       in   1      downstream busy: hold ID/EX contents
//  flush          in   1      squash instruction entering EX (taken branch/jump)
//  exmem_regwrite in 1; exmem_rd in REG_AW; exmem_result in XLEN   EX/MEM bypass source
//  memwb_regwrite in 1; memwb_rd in REG_AW; memwb_result in XLEN   MEM/WB bypass source
//  alu_a          out  XLEN   to ALU A
//  alu_b          out  XLEN   to ALU B
//  alu_ctrl       out  4      to ALU ALUcontrol_In
//  ex_store_data  out  XLEN   forwarded rs2 value, for stores
//  ex_valid/ex_rd/ex_regwrite/ex_memread/ex_memwrite/ex_memtoreg  out  registered controls to EX/MEM
//  load_use_stall out  1      upstream must hold PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset: every register cleared; ex_valid=0, all ex_* controls=0, alu_ctrl=4'b0000, data regs=0.
//  - Per-edge priority: reset > flush > stall_in (hold) > load_use_stall (load bubble) > load id_*.
//  - Bubble: ex_valid, ex_regwrite, ex_memread and ex_memwrite =0; alu_ctrl=0000; rd/rs fields=0.
//  - Latency: one cycle ID->EX. alu_a/alu_b/ex_store_data are combinational from registered state and
//    the current bypass inputs. Forwarding in the same cycle is required.
//  - Hazard: load_use_stall = id_valid & ex_valid & ex_memread & ex_rd!=0 &
//    (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)) & ~flush & ~stall_in. This cost is one bubble, not two.
//  - Forward select, per source: EX/MEM if exmem_regwrite & exmem_rd!=0 & match;
//    otherwise MEM/WB if memwb_regwrite & memwb_rd!=0 & match; otherwise the registered RF data.
//    EX/MEM wins when both match.
//  - alu_a = fwd_rs1. alu_b = ex_alusrc ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2 always.
//  - Shift ops (alu_ctrl 1000/1001/1011): alu_b = {27'b0, B[4:0]}. Any shift amount 0..31 is legal.
//    No input causes shift >= 32.
//  - stall_in held N cycles: outputs stable except for bypass-driven operand changes.
//    The forwarding mux re-evaluates every cycle.
//  - flush coincident with stall_in: flush wins; a bubble loads.
//  - Reset asserted mid-operation: a bubble appears on the following cycle and no stall is pending.
// STRUCTURE
//  - Shared package cpu_pkg:
//    ALU op constants ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110,
//    ALU_SLL=1000, ALU_SRL=1001, ALU_SRA=1011;
//    fwd_sel_t {FWD_RF, FWD_EXMEM, FWD_MEMWB}; XLEN; REG_AW.
//  - One sub-module, forward_unit: pure combinational. Inputs are ex_rs1/ex_rs2 and the bypass
//    rd/regwrite signals; outputs are two fwd_sel_t. Instantiated once.
//  - Pipeline register, hazard logic and operand muxes stay in id_ex_stage.
// TESTING
//  1. Reset held 2 cycles with id_valid=1 -> ex_valid=0, alu_ctrl=0000, load_use_stall=0.
//     First post-reset edge loads id_* values.
//  2. id add rs1=3, rs2=4, rs1_data=5, rs2_data=7, no bypass match -> next cycle alu_a=5, alu_b=7,
//     alu_ctrl=0010.
//  3. ex rs1=3; exmem_rd=3, exmem_result=0x10; memwb_rd=3, memwb_result=0x20 (both regwrite=1)
//     -> alu_a=0x10 (EX/MEM wins). Case exmem_rd=0 -> alu_a=0x20. Case memwb_rd=0 -> alu_a=RF data.
//  4. lw x5 in EX, id_rs2=5, id_uses_rs2=1 -> load_use_stall=1 for exactly 1 cycle; next cycle ex_valid=0.
//     Then the instruction enters EX with alu_b=memwb_result.
//  5. flush=1 with stall_in=1 and a load-use match -> ex_valid=0 next cycle, load_use_stall=0.
//  6. alu_ctrl=1000, alusrc=1, imm=0x00000025 -> alu_b=0x00000005.
//     Then stall_in held 3 cycles -> ex_* unchanged throughout.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU operation codes and the forwarding-source select.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1011;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_t;

    // Contents of the ID/EX pipeline register; an all-zero value is a bubble.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [XLEN-1:0]   rs1Data;
        logic [XLEN-1:0]   rs2Data;
        logic [XLEN-1:0]   imm;
        logic              aluSrc;
        logic [3:0]        aluCtrl;
        logic              regWrite;
        logic              memRead;
        logic              memWrite;
        logic              memToReg;
    } idex_t;

    function automatic logic isShift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/id_ex_if.sv
// Bundle between decode/bypass sources and the ID/EX stage; the stage uses the slave modport.
interface id_ex_if;
    import cpu_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] id_rd;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic              id_alusrc;
    logic [3:0]        id_alu_ctrl;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;
    logic              id_memtoreg;
    logic              stall_in;
    logic              flush;
    logic              exmem_regwrite;
    logic [REG_AW-1:0] exmem_rd;
    logic [XLEN-1:0]   exmem_result;
    logic              memwb_regwrite;
    logic [REG_AW-1:0] memwb_rd;
    logic [XLEN-1:0]   memwb_result;

    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [3:0]        alu_ctrl;
    logic [XLEN-1:0]   ex_store_data;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic              ex_memtoreg;
    logic              load_use_stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alusrc, id_alu_ctrl, id_regwrite, id_memread, id_memwrite, id_memtoreg,
               stall_in, flush, exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        input  alu_a, alu_b, alu_ctrl, ex_store_data, ex_valid, ex_rd, ex_regwrite,
               ex_memread, ex_memwrite, ex_memtoreg, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alusrc, id_alu_ctrl, id_regwrite, id_memread, id_memwrite, id_memtoreg,
               stall_in, flush, exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        output alu_a, alu_b, alu_ctrl, ex_store_data, ex_valid, ex_rd, ex_regwrite,
               ex_memread, ex_memwrite, ex_memtoreg, load_use_stall
    );

endinterface

// File: rtl/forward_unit.sv
// Chooses the bypass source for each EX operand; EX/MEM is newer than MEM/WB so it wins.
module forward_unit
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] ex_rs1_i,
    input  logic [REG_AW-1:0] ex_rs2_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              memwb_regwrite_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    output fwd_sel_t          fwd_a_o,
    output fwd_sel_t          fwd_b_o
);

    // x0 never forwards because a zero destination is excluded before the index compare.
    function automatic fwd_sel_t selectSource(input logic [REG_AW-1:0] rs);
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs)) return FWD_EXMEM;
        if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs)) return FWD_MEMWB;
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_a_o = selectSource(ex_rs1_i);
        fwd_b_o = selectSource(ex_rs2_i);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use bubble insertion.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    id_ex_if.slave  bus
);

    idex_t           idex_q;
    idex_t           idex_d;
    logic            loadUseStall;
    fwd_sel_t        fwdSelA;
    fwd_sel_t        fwdSelB;
    logic [XLEN-1:0] fwdRs1;
    logic [XLEN-1:0] fwdRs2;
    logic [XLEN-1:0] operandB;

    // A flush or downstream stall already disturbs the instruction, so no extra bubble is needed.
    assign loadUseStall = bus.id_valid && idex_q.valid && idex_q.memRead && (idex_q.rd != '0) &&
                          ((idex_q.rd == bus.id_rs1) || (bus.id_uses_rs2 && (idex_q.rd == bus.id_rs2))) &&
                          !bus.flush && !bus.stall_in;

    always_comb begin
        idex_d = idex_q;
        if (bus.flush) begin
            idex_d = '0;
        end else if (bus.stall_in) begin
            idex_d = idex_q;
        end else if (loadUseStall) begin
            idex_d = '0;
        end else begin
            idex_d = '{valid:    bus.id_valid,
                       rd:       bus.id_rd,
                       rs1:      bus.id_rs1,
                       rs2:      bus.id_rs2,
                       rs1Data:  bus.id_rs1_data,
                       rs2Data:  bus.id_rs2_data,
                       imm:      bus.id_imm,
                       aluSrc:   bus.id_alusrc,
                       aluCtrl:  bus.id_alu_ctrl,
                       regWrite: bus.id_regwrite,
                       memRead:  bus.id_memread,
                       memWrite: bus.id_memwrite,
                       memToReg: bus.id_memtoreg};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    forward_unit u_forward_unit (
        .ex_rs1_i         (idex_q.rs1),
        .ex_rs2_i         (idex_q.rs2),
        .exmem_regwrite_i (bus.exmem_regwrite),
        .exmem_rd_i       (bus.exmem_rd),
        .memwb_regwrite_i (bus.memwb_regwrite),
        .memwb_rd_i       (bus.memwb_rd),
        .fwd_a_o          (fwdSelA),
        .fwd_b_o          (fwdSelB)
    );

    always_comb begin
        case (fwdSelA)
            FWD_EXMEM: fwdRs1 = bus.exmem_result;
            FWD_MEMWB: fwdRs1 = bus.memwb_result;
            default:   fwdRs1 = idex_q.rs1Data;
        endcase
        case (fwdSelB)
            FWD_EXMEM: fwdRs2 = bus.exmem_result;
            FWD_MEMWB: fwdRs2 = bus.memwb_result;
            default:   fwdRs2 = idex_q.rs2Data;
        endcase
        operandB = idex_q.aluSrc ? idex_q.imm : fwdRs2;
    end

    assign bus.alu_a          = fwdRs1;
    assign bus.alu_b          = isShift(idex_q.aluCtrl) ? {{(XLEN-5){1'b0}}, operandB[4:0]} : operandB;
    assign bus.alu_ctrl       = idex_q.aluCtrl;
    assign bus.ex_store_data  = fwdRs2;
    assign bus.ex_valid       = idex_q.valid;
    assign bus.ex_rd          = idex_q.rd;
    assign bus.ex_regwrite    = idex_q.regWrite;
    assign bus.ex_memread     = idex_q.memRead;
    assign bus.ex_memwrite    = idex_q.memWrite;
    assign bus.ex_memtoreg    = idex_q.memToReg;
    assign bus.load_use_stall = loadUseStall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model checked every cycle plus literal spot checks.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checksTotal = 0;
    int   checksPassed = 0;
    bit   modelReady = 1'b0;

    always #5 clk = ~clk;

    id_ex_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // The instruction the model believes currently sits in EX.
    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        useImm;
        logic [3:0]  op;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mtr;
    } exSlot_t;

    exSlot_t ex;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Newest writer of a register wins; register 0 always reads its file value.
    function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rfValue);
        if (rs != 0 && bus.exmem_regwrite && bus.exmem_rd == rs) return bus.exmem_result;
        if (rs != 0 && bus.memwb_regwrite && bus.memwb_rd == rs) return bus.memwb_result;
        return rfValue;
    endfunction

    function automatic logic expectStall();
        logic readsLoadDest;
        readsLoadDest = (ex.rd == bus.id_rs1) || (bus.id_uses_rs2 && ex.rd == bus.id_rs2);
        return bus.id_valid && ex.valid && ex.mr && ex.rd != 0 && readsLoadDest &&
               !bus.flush && !bus.stall_in;
    endfunction

    // Model advance: reset, then flush, then hold, then load bubble, otherwise take the decode slot.
    always @(posedge clk) begin
        if (reset) begin
            ex <= '{default: '0};
            modelReady <= 1'b1;
        end else if (bus.flush) begin
            ex <= '{default: '0};
        end else if (bus.stall_in) begin
            ex <= ex;
        end else if (expectStall()) begin
            ex <= '{default: '0};
        end else begin
            ex <= '{valid: bus.id_valid, rd: bus.id_rd, rs1: bus.id_rs1, rs2: bus.id_rs2,
                    d1: bus.id_rs1_data, d2: bus.id_rs2_data, imm: bus.id_imm,
                    useImm: bus.id_alusrc, op: bus.id_alu_ctrl, rw: bus.id_regwrite,
                    mr: bus.id_memread, mw: bus.id_memwrite, mtr: bus.id_memtoreg};
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        logic [31:0] expA;
        logic [31:0] expStore;
        logic [31:0] expB;
        if (modelReady) begin
            expA     = resolve(ex.rs1, ex.d1);
            expStore = resolve(ex.rs2, ex.d2);
            expB     = ex.useImm ? ex.imm : expStore;
            if (ex.op == 4'b1000 || ex.op == 4'b1001 || ex.op == 4'b1011) expB = expB % 32;
            checkOutput("model alu_a", bus.alu_a, expA);
            checkOutput("model alu_b", bus.alu_b, expB);
            checkOutput("model alu_ctrl", {28'b0, bus.alu_ctrl}, {28'b0, ex.op});
            checkOutput("model store_data", bus.ex_store_data, expStore);
            checkOutput("model ex_valid", {31'b0, bus.ex_valid}, {31'b0, ex.valid});
            checkOutput("model ex_rd", {27'b0, bus.ex_rd}, {27'b0, ex.rd});
            checkOutput("model ex_regwrite", {31'b0, bus.ex_regwrite}, {31'b0, ex.rw});
            checkOutput("model ex_memread", {31'b0, bus.ex_memread}, {31'b0, ex.mr});
            checkOutput("model ex_memwrite", {31'b0, bus.ex_memwrite}, {31'b0, ex.mw});
            checkOutput("model ex_memtoreg", {31'b0, bus.ex_memtoreg}, {31'b0, ex.mtr});
            checkOutput("model load_use_stall", {31'b0, bus.load_use_stall}, {31'b0, expectStall()});
        end
    end

    task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic usesRs2, input logic [4:0] rd,
                                 input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                 input logic aluSrc, input logic [3:0] op,
                                 input logic rw, input logic mr, input logic mw, input logic mtr);
        bus.id_valid    = valid;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_uses_rs2 = usesRs2;
        bus.id_rd       = rd;
        bus.id_rs1_data = d1;
        bus.id_rs2_data = d2;
        bus.id_imm      = imm;
        bus.id_alusrc   = aluSrc;
        bus.id_alu_ctrl = op;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.id_memwrite = mw;
        bus.id_memtoreg = mtr;
    endtask

    task automatic applyBypass(input logic exRw, input logic [4:0] exRd, input logic [31:0] exRes,
                               input logic wbRw, input logic [4:0] wbRd, input logic [31:0] wbRes);
        bus.exmem_regwrite = exRw;
        bus.exmem_rd       = exRd;
        bus.exmem_result   = exRes;
        bus.memwb_regwrite = wbRw;
        bus.memwb_rd       = wbRd;
        bus.memwb_result   = wbRes;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        applyBypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        // add x6 = x3 + x4, offered while reset is held
        applyStimulus(1'b1, 5'd3, 5'd4, 1'b1, 5'd6, 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ex_valid", {31'b0, bus.ex_valid}, 32'd0);
        checkOutput("reset alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd0);
        checkOutput("reset load_use_stall", {31'b0, bus.load_use_stall}, 32'd0);

        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("add alu_a", bus.alu_a, 32'd5);
        checkOutput("add alu_b", bus.alu_b, 32'd7);
        checkOutput("add alu_ctrl", {28'b0, bus.alu_ctrl}, 32'b0010);
        checkOutput("add ex_valid", {31'b0, bus.ex_valid}, 32'd1);

        // hold the add in EX while the bypass sources change underneath it
        #1 bus.stall_in = 1'b1;
        applyBypass(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        @(negedge clk);
        checkOutput("fwd exmem wins", bus.alu_a, 32'h10);
        checkOutput("fwd store no match", bus.ex_store_data, 32'd7);
        #1 applyBypass(1'b1, 5'd0, 32'h10, 1'b1, 5'd3, 32'h20);
        @(negedge clk);
        checkOutput("fwd memwb", bus.alu_a, 32'h20);
        #1 applyBypass(1'b1, 5'd0, 32'h10, 1'b1, 5'd0, 32'h20);
        @(negedge clk);
        checkOutput("fwd rf data", bus.alu_a, 32'd5);

        // lw x5, 8(x2) followed by add x7 = x1 + x5
        #1 bus.stall_in = 1'b0;
        applyBypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, 5'd2, 5'd0, 1'b0, 5'd5, 32'h100, 32'h0, 32'd8, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("lw alu_a", bus.alu_a, 32'h100);
        checkOutput("lw alu_b", bus.alu_b, 32'd8);
        checkOutput("lw ex_memread", {31'b0, bus.ex_memread}, 32'd1);
        #1 applyStimulus(1'b1, 5'd1, 5'd5, 1'b1, 5'd7, 32'h11, 32'hDEAD, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("load-use stall raised", {31'b0, bus.load_use_stall}, 32'd1);
        @(negedge clk);
        checkOutput("bubble ex_valid", {31'b0, bus.ex_valid}, 32'd0);
        checkOutput("bubble ex_regwrite", {31'b0, bus.ex_regwrite}, 32'd0);
        checkOutput("bubble stall cleared", {31'b0, bus.load_use_stall}, 32'd0);
        #1 applyBypass(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h55);
        @(negedge clk);
        checkOutput("dep ex_valid", {31'b0, bus.ex_valid}, 32'd1);
        checkOutput("dep alu_a", bus.alu_a, 32'h11);
        checkOutput("dep alu_b from memwb", bus.alu_b, 32'h55);

        // flush together with stall_in and a load-use match
        #1 applyBypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, 5'd2, 5'd0, 1'b0, 5'd5, 32'h100, 32'h0, 32'd8, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #1 applyStimulus(1'b1, 5'd1, 5'd5, 1'b1, 5'd7, 32'h11, 32'hDEAD, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.stall_in = 1'b1;
        bus.flush    = 1'b1;
        #1 checkOutput("flush suppresses stall", {31'b0, bus.load_use_stall}, 32'd0);
        @(negedge clk);
        checkOutput("flush ex_valid", {31'b0, bus.ex_valid}, 32'd0);
        checkOutput("flush ex_memread", {31'b0, bus.ex_memread}, 32'd0);

        // slli x8, x1, 0x25 then hold it for three cycles
        #1 bus.flush = 1'b0;
        bus.stall_in = 1'b0;
        applyStimulus(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 32'h3, 32'h0, 32'h25, 1'b1, ALU_SLL, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("sll alu_b masked", bus.alu_b, 32'h5);
        checkOutput("sll alu_ctrl", {28'b0, bus.alu_ctrl}, 32'b1000);
        #1 bus.stall_in = 1'b1;
        applyStimulus(1'b1, 5'd2, 5'd9, 1'b1, 5'd10, 32'h80, 32'hFFFF_FFE3, 32'h0, 1'b0, ALU_SRA, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold ex_rd", {27'b0, bus.ex_rd}, 32'd8);
            checkOutput("hold alu_b", bus.alu_b, 32'h5);
            checkOutput("hold alu_ctrl", {28'b0, bus.alu_ctrl}, 32'b1000);
        end
        #1 bus.stall_in = 1'b0;
        @(negedge clk);
        checkOutput("sra alu_b masked", bus.alu_b, 32'h3);
        checkOutput("sra store_data", bus.ex_store_data, 32'hFFFF_FFE3);
        checkOutput("sra ex_rd", {27'b0, bus.ex_rd}, 32'd10);

        // reset arriving while a load-use hazard is pending
        #1 applyStimulus(1'b1, 5'd2, 5'd0, 1'b0, 5'd5, 32'h100, 32'h0, 32'd8, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #1 applyStimulus(1'b1, 5'd5, 5'd0, 1'b0, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0, ALU_OR, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid reset ex_valid", {31'b0, bus.ex_valid}, 32'd0);
        checkOutput("mid reset stall", {31'b0, bus.load_use_stall}, 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("post reset ex_rd", {27'b0, bus.ex_rd}, 32'd7);
        checkOutput("post reset alu_ctrl", {28'b0, bus.alu_ctrl}, 32'b0001);

        @(posedge clk);
        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
